// File: rtl/ex_wb_fwd_stage.sv
// EX/WB pipeline register with register-file write-back and a one-level
// forwarding select for the shifter operand (result vs. pass-through data).
module ex_wb_fwd_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic       ex_regwrite,
  input  logic       ex_is_shift,
  input  logic [2:0] ex_rd,
  input  logic [2:0] ex_rs,
  input  logic [7:0] ex_shift_result,
  input  logic [7:0] ex_data1,
  input  logic       stall,
  input  logic       flush,
  output logic [7:0] EX_WB_Shift_Result,
  output logic [7:0] EX_WB_Data1,
  output logic [1:0] FwdCtrl,
  output logic       wb_we,
  output logic [2:0] wb_rd,
  output logic [7:0] wb_data,
  output logic       wb_valid
);

  localparam logic [1:0] FWD_SHIFT = 2'b00;
  localparam logic [1:0] FWD_DATA1 = 2'b01;
  localparam logic [1:0] FWD_NONE  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       is_shift;
    logic [2:0] rd;
    logic [7:0] shift_result;
    logic [7:0] data1;
  } exwb_t;

  exwb_t r;
  exwb_t ex_in;
  logic  commit;

  assign ex_in = '{valid:        ex_valid,
                   regwrite:     ex_regwrite,
                   is_shift:     ex_is_shift,
                   rd:           ex_rd,
                   shift_result: ex_shift_result,
                   data1:        ex_data1};

  // Flush only kills control bits; data fields stay put so a bubble is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (flush) begin
      r.valid    <= 1'b0;
      r.regwrite <= 1'b0;
    end else if (!stall) begin
      r <= ex_in;
    end
  end

  // r0 is hard-wired zero: never written, never a forwarding source.
  assign commit = r.valid & r.regwrite & (r.rd != 3'd0);

  // A stalled entry is re-presented next cycle, so suppress the write now.
  assign wb_we    = commit & ~stall;
  assign wb_rd    = r.rd;
  assign wb_data  = r.is_shift ? r.shift_result : r.data1;
  assign wb_valid = r.valid;

  assign EX_WB_Shift_Result = r.shift_result;
  assign EX_WB_Data1        = r.data1;

  always_comb begin
    FwdCtrl = FWD_NONE;
    if (ex_valid && commit && (r.rd == ex_rs))
      FwdCtrl = r.is_shift ? FWD_SHIFT : FWD_DATA1;
  end

endmodule

// File: tb/tb_ex_wb_fwd_stage.sv
// Directed bench for ex_wb_fwd_stage: capture, forwarding, r0, stall/flush,
// async reset and back-to-back write-back.
module tb_ex_wb_fwd_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid, ex_regwrite, ex_is_shift;
  logic [2:0] ex_rd, ex_rs;
  logic [7:0] ex_shift_result, ex_data1;
  logic       stall, flush;
  logic [7:0] EX_WB_Shift_Result, EX_WB_Data1, wb_data;
  logic [1:0] FwdCtrl;
  logic       wb_we, wb_valid;
  logic [2:0] wb_rd;

  int vectors = 0;
  int miscompares = 0;

  ex_wb_fwd_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_shift(ex_is_shift),
    .ex_rd(ex_rd), .ex_rs(ex_rs),
    .ex_shift_result(ex_shift_result), .ex_data1(ex_data1),
    .stall(stall), .flush(flush),
    .EX_WB_Shift_Result(EX_WB_Shift_Result), .EX_WB_Data1(EX_WB_Data1),
    .FwdCtrl(FwdCtrl), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic sh,
                       input logic [2:0] rd, input logic [2:0] rs,
                       input logic [7:0] sr, input logic [7:0] d1);
    ex_valid = v; ex_regwrite = rw; ex_is_shift = sh;
    ex_rd = rd; ex_rs = rs; ex_shift_result = sr; ex_data1 = d1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".we"},    {7'd0, wb_we},    8'h00);
    chk({tag, ".valid"}, {7'd0, wb_valid}, 8'h00);
    chk({tag, ".data"},  wb_data,          8'h00);
    chk({tag, ".rd"},    {5'd0, wb_rd},    8'h00);
    chk({tag, ".sr"},    EX_WB_Shift_Result, 8'h00);
    chk({tag, ".d1"},    EX_WB_Data1,      8'h00);
    chk({tag, ".fwd"},   {6'd0, FwdCtrl},  8'h02);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 8'hA4, 8'h55);
    #12;
    chk_reset("reset");
    #1 rst_n = 1'b1;

    // Capture + forward from shift result
    step();
    chk("cap.we",   {7'd0, wb_we}, 8'h01);
    chk("cap.rd",   {5'd0, wb_rd}, 8'h03);
    chk("cap.data", wb_data, 8'hA4);
    chk("cap.sr",   EX_WB_Shift_Result, 8'hA4);
    chk("cap.d1",   EX_WB_Data1, 8'h55);
    chk("cap.fwd",  {6'd0, FwdCtrl}, 8'h00);

    // Move: forward data1
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd5, 8'h99, 8'h3C);
    #1 chk("mv.pre_fwd", {6'd0, FwdCtrl}, 8'h02);
    step();
    chk("mv.data", wb_data, 8'h3C);
    chk("mv.fwd",  {6'd0, FwdCtrl}, 8'h01);
    ex_rs = 3'd4;
    #1 chk("mv.fwd_rs4", {6'd0, FwdCtrl}, 8'h02);
    ex_rs = 3'd5; ex_valid = 1'b0;
    #1 chk("mv.fwd_exinv", {6'd0, FwdCtrl}, 8'h02);

    // r0 suppression
    drive(1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 8'h77, 8'h66);
    step();
    chk("r0.we",    {7'd0, wb_we}, 8'h00);
    chk("r0.valid", {7'd0, wb_valid}, 8'h01);
    chk("r0.fwd",   {6'd0, FwdCtrl}, 8'h02);

    // Stall / flush
    drive(1'b1, 1'b1, 1'b0, 3'd2, 3'd2, 8'h00, 8'h11);
    step();
    chk("ld.we",   {7'd0, wb_we}, 8'h01);
    chk("ld.rd",   {5'd0, wb_rd}, 8'h02);
    chk("ld.data", wb_data, 8'h11);
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3'd6, 3'd2, 8'hEE, 8'hEE);
    #1 chk("st.we_now", {7'd0, wb_we}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st.rd",   {5'd0, wb_rd}, 8'h02);
      chk("st.data", wb_data, 8'h11);
      chk("st.we",   {7'd0, wb_we}, 8'h00);
    end
    flush = 1'b1;
    step();
    chk("fl.valid", {7'd0, wb_valid}, 8'h00);
    chk("fl.we",    {7'd0, wb_we}, 8'h00);
    chk("fl.fwd",   {6'd0, FwdCtrl}, 8'h02);
    chk("fl.d1",    EX_WB_Data1, 8'h11);
    stall = 1'b0; flush = 1'b0;

    // Async reset with a committable entry held
    drive(1'b1, 1'b1, 1'b1, 3'd7, 3'd7, 8'h5A, 8'hC3);
    step();
    chk("ar.we_pre",  {7'd0, wb_we}, 8'h01);
    chk("ar.fwd_pre", {6'd0, FwdCtrl}, 8'h00);
    #2 rst_n = 1'b0;
    #1 chk_reset("areset");
    stall = 1'b1; flush = 1'b1;
    step();
    chk_reset("areset_hold");
    stall = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b1;

    // Back-to-back rd = 1, 2, 1
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd0, 8'h00, 8'h10);
    step();
    chk("bb1.rd",   {5'd0, wb_rd}, 8'h01);
    chk("bb1.data", wb_data, 8'h10);
    drive(1'b1, 1'b1, 1'b0, 3'd2, 3'd1, 8'h00, 8'h20);
    #1 chk("bb1.fwd", {6'd0, FwdCtrl}, 8'h01);
    step();
    chk("bb2.rd",   {5'd0, wb_rd}, 8'h02);
    chk("bb2.data", wb_data, 8'h20);
    chk("bb2.fwd_old_rs", {6'd0, FwdCtrl}, 8'h02);
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 8'h00, 8'h30);
    #1 chk("bb2.fwd", {6'd0, FwdCtrl}, 8'h01);
    step();
    chk("bb3.rd",   {5'd0, wb_rd}, 8'h01);
    chk("bb3.data", wb_data, 8'h30);
    chk("bb3.we",   {7'd0, wb_we}, 8'h01);
    chk("bb3.fwd",  {6'd0, FwdCtrl}, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ex_wb_fwd_stage.md
EX_WB_FWD_STAGE -- requirements
Module: ex_wb_fwd_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the reset port is named rst_n and the clock port is named clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ex_valid  input  1  the EX stage holds a real instruction.
REQ-005 ex_regwrite  input  1  the EX instruction writes the register file.
REQ-006 ex_is_shift  input  1  1 = result is ex_shift_result; 0 = result is ex_data1 (move/pass).
REQ-007 ex_rd  input  3  destination register of the EX instruction.
REQ-008 ex_rs  input  3  source register read by the instruction now in EX (the shift operand).
REQ-009 ex_shift_result  input  8  shifter output this cycle.
REQ-010 ex_data1  input  8  operand-1 value of the EX instruction.
REQ-011 stall  input  1  hold the EX/WB register contents.
REQ-012 flush  input  1  load a bubble into EX/WB.
REQ-013 EX_WB_Shift_Result  output  8  registered shift result.
REQ-014 EX_WB_Data1  output  8  registered operand-1.
REQ-015 FwdCtrl  output  2  operand select for the shifter: 00 = EX_WB_Shift_Result, 01 = EX_WB_Data1, 10 = no forward.
REQ-016 wb_we  output  1  register-file write enable.
REQ-017 wb_rd  output  3  register-file write address.
REQ-018 wb_data  output  8  register-file write data.
REQ-019 wb_valid  output  1  the WB stage holds a real instruction.

Function
REQ-020 The EX/WB register SHALL consist of valid, regwrite, is_shift, rd[2:0], shift_result[7:0], and data1[7:0], all updated on the rising clk edge.
REQ-021 The register SHALL capture all ex_* inputs when stall=0 and flush=0.
REQ-022 The register SHALL hold all contents unchanged when stall=1 and flush=0.
REQ-023 When flush=1, the register SHALL clear valid and regwrite, and SHALL leave the data fields unchanged; flush takes priority over stall.
REQ-024 An entry SHALL be committable only when valid=1, regwrite=1, and rd!=0.
REQ-025 Register 0 is hard-wired to zero; an entry with rd=0 SHALL never assert wb_we and SHALL never forward.
REQ-026 wb_we SHALL be combinationally equal to the committable condition.
REQ-027 wb_rd SHALL equal the registered rd.
REQ-028 wb_data SHALL be the registered shift_result when is_shift=1, and the registered data1 otherwise.
REQ-029 wb_valid SHALL equal the registered valid.
REQ-030 While stall=1, wb_we SHALL be forced to 0 so that a held instruction commits only once.
REQ-031 FwdCtrl SHALL be combinational from current-cycle inputs and state, with zero-cycle latency.
REQ-032 FwdCtrl SHALL be 00 when the entry is committable, rd==ex_rs, and is_shift=1.
REQ-033 FwdCtrl SHALL be 01 when the entry is committable, rd==ex_rs, and is_shift=0.
REQ-034 FwdCtrl SHALL be 10 in every other case, including ex_valid=0.
REQ-035 FwdCtrl SHALL never take the value 11.
REQ-036 EX_WB_Shift_Result and EX_WB_Data1 SHALL directly reflect the registered fields.
REQ-037 Latency from ex_* to the wb_* outputs SHALL be exactly one cycle absent stall.
REQ-038 No arithmetic is performed; all data paths SHALL be 8 bits with no width extension.

Reset
REQ-039 On rst_n=0, all register fields SHALL clear to 0 immediately, without waiting for clk.
REQ-040 During reset, wb_we=0, wb_valid=0, wb_data=8'h00, wb_rd=3'd0, EX_WB_Shift_Result=8'h00, EX_WB_Data1=8'h00, and FwdCtrl=10.
REQ-041 Reset asserted mid-stall or mid-flush SHALL override both.
REQ-042 The first capture after reset release SHALL occur on the first clk edge with rst_n=1.

Verification
REQ-043 Capture and forward shift: ex_valid=1, ex_regwrite=1, ex_is_shift=1, ex_rd=3, ex_shift_result=8'hA4 -> next cycle wb_we=1, wb_rd=3, wb_data=8'hA4; with ex_rs=3, FwdCtrl=00.
REQ-044 Move forward: ex_is_shift=0, ex_rd=5, ex_data1=8'h3C -> next cycle wb_data=8'h3C; with ex_rs=5, FwdCtrl=01; with ex_rs=4, FwdCtrl=10.
REQ-045 r0 suppression: ex_rd=0, ex_regwrite=1, ex_valid=1, ex_rs=0 -> next cycle wb_we=0 and FwdCtrl=10.
REQ-046 Stall/flush: load rd=2 with data 8'h11, then hold stall=1 for 3 cycles -> fields hold and wb_we=0 throughout; then assert stall=1 and flush=1 together -> next cycle wb_valid=0, wb_we=0, FwdCtrl=10.
REQ-047 Async reset: with a committable entry held, drive rst_n low between clock edges -> all outputs reach reset values before the next edge.
REQ-048 Back-to-back: three consecutive instructions writing rd=1, 2, 1 -> wb_rd sequence 1, 2, 1 on consecutive cycles; FwdCtrl tracks the current ex_rs each cycle.
